v_uresizer_1ppc: RTL
====================

Name: v_uresizer_1ppc

Overview:
- 2x video upscaler on AXI4-Stream video at 1 pixel per clock. It is the counterpart of the downscaling resizer.
- Horizontal upscaling replicates each pixel (COLUMN_UP). Vertical upscaling replays each stored line a second time from an internal line buffer (LINE_UP).
- Sits between the video input pipeline and the output timing/VDMA path. Frames use tuser as SOF and tlast as EOL.

Parameters:
- COLUMN_UP, 1, 1 = emit every input pixel twice per line.
- LINE_UP, 1, 1 = emit every input line twice.
- PIXEL_WIDTH, 24, bits per pixel in tdata.
- MAX_COLUMNS, 2048, line buffer depth in pixels.
- ADDR_WIDTH, 11, line buffer address width; must satisfy 2^ADDR_WIDTH >= MAX_COLUMNS.

Ports:
- aclk, input, 1, single clock; all logic on rising edge.
- areset, input, 1, asynchronous active-high reset.
- s_axis_tdata, input, PIXEL_WIDTH, input pixel.
- s_axis_tvalid, input, 1, input valid.
- s_axis_tready, output, 1, input ready.
- s_axis_tuser, input, 1, start of frame.
- s_axis_tlast, input, 1, end of line.
- m_axis_tdata, output, PIXEL_WIDTH, output pixel (registered).
- m_axis_tvalid, output, 1, output valid (registered).
- m_axis_tready, input, 1, output ready.
- m_axis_tuser, output, 1, start of frame (registered).
- m_axis_tlast, output, 1, end of line (registered).

Behaviour:
- Reset values: m_axis_tvalid/tuser/tlast = 0; m_axis_tdata = 0; s_axis_tready = 0; state = LIVE; hphase = 0; wr_addr = 0; line_len = 0.
- Output register:
  - Loads when (!m_axis_tvalid || m_axis_tready) and a source pixel is available; otherwise holds all m_* fields stable.
  - m_axis_tvalid drops only when the register is consumed and nothing new loads.
- LIVE state:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready) && hphase==0. It is combinational from registered state and m_axis_tready only, never from s_axis_tvalid.
  - On input accept: output copy 0 with tdata = s_axis_tdata, tuser = s_axis_tuser, tlast = s_axis_tlast && !COLUMN_UP. Write the pixel to buffer[wr_addr]; latch tdata/tlast.
  - If COLUMN_UP: set hphase = 1. The next output load emits copy 1 with the latched data, tuser = 0, tlast = latched tlast, then clears hphase.
  - End of line, i.e. the final copy carrying tlast is loaded:
    - line_len = wr_addr + 1; wr_addr = 0.
    - If LINE_UP, go to REPLAY; else stay in LIVE.
- Latency: 1 clock from input handshake to m_axis_tvalid with an idle output.
- REPLAY state:
  - s_axis_tready = 0.
  - Synchronous-read buffer with 1-cycle read latency, prefetched so replay sustains 1 output pixel per clock under continuous m_axis_tready (2 copies/pixel if COLUMN_UP).
  - tuser = 0 on all replay beats.
  - tlast = 1 only on the final copy of pixel line_len-1. After that copy loads, go to LIVE.
- SOF mid-line (tuser on a pixel while wr_addr != 0): the pixel is forwarded with tuser = 1 and written at address 0; wr_addr restarts at 1. No flush and no replay of the partial line.
- Line longer than MAX_COLUMNS: excess pixels are still passed live. Writes are suppressed once wr_addr = MAX_COLUMNS-1 has been written. line_len saturates at MAX_COLUMNS, so replay emits MAX_COLUMNS pixels.
- Backpressure: input stall (s_axis_tvalid = 0) in LIVE inserts bubbles only, with no state change. m_axis_tready = 0 freezes all state in both LIVE and REPLAY.
- Reset mid-line or mid-replay: immediately returns to reset values. Buffer contents are don't-care; the partial line is lost.
- COLUMN_UP = 0 and LINE_UP = 0: pure 1-stage registered pass-through.

Test Plan:
- 4x2 frame, pixels 0x000001..0x000008, tuser on the first pixel, tlast every 4th, continuous ready, defaults -> 32 beats. Line 0 is 1,1,2,2,3,3,4,4 emitted twice, then line 1 is 5,5,...,8,8 emitted twice. tuser only on beat 0; tlast on beats 7, 15, 23, 31.
- Same frame with m_axis_tready toggling 1/0 every cycle -> identical beat sequence, m_* stable while stalled, s_axis_tready = 0 throughout replay.
- COLUMN_UP = 0, LINE_UP = 1, 3-pixel lines A,B,C -> A,B,C(tlast),A,B,C(tlast), with s_axis_tready low for the 3 replay beats.
- COLUMN_UP = 1, LINE_UP = 0, input 0xAA(tuser), 0xBB(tlast) -> 0xAA(tuser), 0xAA, 0xBB, 0xBB(tlast), 1-cycle latency.
- MAX_COLUMNS = 4, 6-pixel line, LINE_UP only -> live pass emits 6 pixels; replay emits pixels 1..4 with tlast on 4.
- Assert areset during the replay of line 0 -> m_axis_tvalid = 0 on the next edge. A new frame after release is output correctly from its first pixel.

Source files
------------

// File: rtl/v_uresizer_1ppc.sv
// 2x video upscaler, 1 pixel per clock: horizontal pixel replication plus
// vertical line replay from an internal line buffer.
module v_uresizer_1ppc #(
  parameter int unsigned COLUMN_UP   = 1,
  parameter int unsigned LINE_UP     = 1,
  parameter int unsigned PIXEL_WIDTH = 24,
  parameter int unsigned MAX_COLUMNS = 2048,
  parameter int unsigned ADDR_WIDTH  = 11
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic COL_UP = (COLUMN_UP != 0);
  localparam logic LN_UP  = (LINE_UP != 0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COLUMNS);

  typedef enum logic {LIVE = 1'b0, REPLAY = 1'b1} state_t;

  state_t state, state_nxt;

  logic                   hphase;
  logic [CNT_W-1:0]       wr_addr, line_len, rd_addr;
  logic [PIXEL_WIDTH-1:0] lat_data, rd_data;
  logic                   lat_last, rd_valid, rd_last;
  logic [PIXEL_WIDTH-1:0] mem [MAX_COLUMNS];

  logic                   out_ready, accept, load, ld_user, ld_last;
  logic                   eol, consume, rd_en, final_copy;
  logic [PIXEL_WIDTH-1:0] ld_data;
  logic [CNT_W-1:0]       wr_next;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_idx;

  // SOF restarts the line at address 0; the write pointer saturates at MAX_COLUMNS
  assign wr_next = s_axis_tuser ? CNT_W'(1)
                 : ((wr_addr >= MAX_CNT) ? wr_addr : wr_addr + CNT_W'(1));
  assign wr_en   = accept && (s_axis_tuser || (wr_addr < MAX_CNT));
  assign wr_idx  = s_axis_tuser ? '0 : wr_addr[ADDR_WIDTH-1:0];

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= LIVE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LIVE:    if (eol && LN_UP) state_nxt = REPLAY;
      REPLAY:  if (load && ld_last) state_nxt = LIVE;
      default: state_nxt = LIVE;
    endcase
  end

  // per-state datapath control
  always_comb begin
    out_ready     = !m_axis_tvalid || m_axis_tready;
    final_copy    = !COL_UP || hphase;
    s_axis_tready = 1'b0;
    accept        = 1'b0;
    load          = 1'b0;
    ld_data       = lat_data;
    ld_user       = 1'b0;
    ld_last       = 1'b0;
    eol           = 1'b0;
    consume       = 1'b0;
    rd_en         = 1'b0;
    case (state)
      LIVE: begin
        s_axis_tready = out_ready && !hphase && !areset;
        accept        = s_axis_tready && s_axis_tvalid;
        if (hphase) begin
          load    = out_ready;
          ld_last = lat_last;
        end else if (accept) begin
          load    = 1'b1;
          ld_data = s_axis_tdata;
          ld_user = s_axis_tuser;
          ld_last = s_axis_tlast && !COL_UP;
        end
        eol = load && ld_last;
      end
      REPLAY: begin
        load    = out_ready && rd_valid;
        ld_data = rd_data;
        ld_last = rd_last && final_copy;
        consume = load && final_copy;
        // prefetch the next pixel as soon as the held one is consumed
        rd_en   = out_ready && (rd_addr < line_len) && (!rd_valid || consume);
      end
      default: ;
    endcase
  end

  // live-side phase, write pointer and line length
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hphase   <= 1'b0;
      wr_addr  <= '0;
      line_len <= '0;
      lat_data <= '0;
      lat_last <= 1'b0;
    end else if (state == LIVE) begin
      if (accept) begin
        lat_data <= s_axis_tdata;
        lat_last <= s_axis_tlast;
        if (COL_UP) hphase <= 1'b1;
      end else if (load) begin
        hphase <= 1'b0;
      end
      if (eol) begin
        line_len <= COL_UP ? wr_addr : wr_next;
        wr_addr  <= '0;
      end else if (accept) begin
        wr_addr <= wr_next;
      end
    end else if (load && COL_UP) begin
      hphase <= !hphase;
    end
  end

  // replay read pointer and prefetch flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (state == LIVE) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_addr  <= rd_addr + CNT_W'(1);
      rd_valid <= 1'b1;
      rd_last  <= (rd_addr == line_len - CNT_W'(1));
    end else if (consume) begin
      rd_valid <= 1'b0;
    end
  end

  // line buffer, synchronous read
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_idx] <= s_axis_tdata;
    if (rd_en) rd_data <= mem[rd_addr[ADDR_WIDTH-1:0]];
  end

  // output register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= ld_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tuser  <= ld_user;
      m_axis_tlast  <= ld_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
